// File: rtl/sort_pkg.sv
// sort_pkg: shared state encoding, priority compare and address-width helper for the heap sorter.
package sort_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, BUILD, HEAPIFY, WRITE, EXTRACT, FINISH} state_t;
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction
  // True when x must sit above y: max-heap for ascending output, min-heap for descending.
  function automatic logic prio(input logic desc, input logic [31:0] x, input logic [31:0] y);
    return desc ? (x < y) : (x > y);
  endfunction
endpackage

// File: rtl/heap_node_sel.sv
// heap_node_sel: picks the higher-priority child of a heap node and flags whether it must swap.
module heap_node_sel import sort_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = addr_w(DEPTH)
) (
  input  logic [ADDR_W:0]   i_index,
  input  logic [ADDR_W:0]   i_num,
  input  logic              i_desc,
  input  logic [DATA_W-1:0] i_heap [1:DEPTH],
  output logic [ADDR_W:0]   o_child,
  output logic              o_swap
);
  logic [ADDR_W+1:0] w_l, w_r;
  logic [DATA_W-1:0] w_lv, w_rv, w_pv, w_cv;
  logic w_has_l, w_has_r, w_pick_r;
  // One extra bit keeps 2i+1 from wrapping for the deepest nodes.
  assign w_l      = {i_index, 1'b0};
  assign w_r      = {i_index, 1'b1};
  assign w_has_l  = w_l <= {1'b0, i_num};
  assign w_has_r  = w_r <= {1'b0, i_num};
  assign w_lv     = w_has_l ? i_heap[w_l[ADDR_W:0]] : '0;
  assign w_rv     = w_has_r ? i_heap[w_r[ADDR_W:0]] : '0;
  assign w_pv     = i_heap[i_index];
  assign w_pick_r = w_has_r && prio(i_desc, 32'(w_rv), 32'(w_lv));
  assign w_cv     = w_pick_r ? w_rv : w_lv;
  assign o_child  = w_pick_r ? w_r[ADDR_W:0] : w_l[ADDR_W:0];
  assign o_swap   = w_has_l && prio(i_desc, 32'(w_cv), 32'(w_pv));
endmodule

// File: rtl/heap_sort_param.sv
// heap_sort_param: loads keys from a sync ROM, heap-sorts them in registers and streams the
// sorted keys to a write-only RAM, highest address first.
module heap_sort_param import sort_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W:0]   cfg_len,
  input  logic              cfg_desc,
  output logic              busy,
  output logic              done,
  output logic              IROM_rd,
  output logic [ADDR_W-1:0] IROM_A,
  input  logic [DATA_W-1:0] IROM_Q,
  output logic              IRAM_valid,
  output logic [ADDR_W-1:0] IRAM_A,
  output logic [DATA_W-1:0] IRAM_D
);
  localparam int LEN_W = ADDR_W + 1;
  state_t r_state, w_next;
  logic [LEN_W-1:0] r_cnt, r_num, r_index, w_len, w_child;
  logic [ADDR_W-1:0] r_build;
  logic r_desc, r_ret_write, w_swap;
  logic [DATA_W-1:0] r_heap [1:DEPTH];
  assign w_len = cfg_len > LEN_W'(DEPTH) ? LEN_W'(DEPTH) : cfg_len;
  heap_node_sel #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_sel (
    .i_index(r_index),
    .i_num  (r_num),
    .i_desc (r_desc),
    .i_heap (r_heap),
    .o_child(w_child),
    .o_swap (w_swap)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = !start ? IDLE : (w_len == '0 ? FINISH : LOAD);
      LOAD:    w_next = r_cnt == r_num ? BUILD : LOAD;
      BUILD:   w_next = r_build == '0 ? WRITE : HEAPIFY;
      HEAPIFY: w_next = w_swap ? HEAPIFY : (r_ret_write ? WRITE : BUILD);
      WRITE:   w_next = r_num == LEN_W'(1) ? FINISH : EXTRACT;
      EXTRACT: w_next = HEAPIFY;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_cnt       <= '0;
      r_num       <= '0;
      r_index     <= '0;
      r_build     <= '0;
      r_desc      <= 1'b0;
      r_ret_write <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_num  <= w_len;
          r_desc <= cfg_desc;
          r_cnt  <= '0;
        end
        LOAD: begin
          r_cnt   <= r_cnt + LEN_W'(1);
          r_build <= ADDR_W'(r_num >> 1);
        end
        BUILD: if (r_build != '0) begin
          r_index     <= {1'b0, r_build};
          r_build     <= r_build - ADDR_W'(1);
          r_ret_write <= 1'b0;
        end
        HEAPIFY: if (w_swap) r_index <= w_child;
        EXTRACT: begin
          r_num       <= r_num - LEN_W'(1);
          r_index     <= LEN_W'(1);
          r_ret_write <= 1'b1;
        end
        default: ;
      endcase
    end
  // ROM data lags its address by one cycle, so slot k is filled while address k is issued.
  always_ff @(posedge clk)
    case (r_state)
      LOAD: if (r_cnt != '0) r_heap[r_cnt] <= IROM_Q;
      HEAPIFY: if (w_swap) begin
        r_heap[r_index] <= r_heap[w_child];
        r_heap[w_child] <= r_heap[r_index];
      end
      EXTRACT: r_heap[1] <= r_heap[r_num];
      default: ;
    endcase
  assign busy       = r_state != IDLE;
  assign done       = r_state == FINISH;
  assign IROM_rd    = r_state == LOAD && r_cnt < r_num;
  assign IROM_A     = IROM_rd ? ADDR_W'(r_cnt) : '0;
  assign IRAM_valid = r_state == WRITE;
  assign IRAM_A     = IRAM_valid ? ADDR_W'(r_num - LEN_W'(1)) : '0;
  assign IRAM_D     = IRAM_valid ? r_heap[1] : '0;
endmodule
